// File: rtl/ripple_cnt_capture.sv
// ---------------------------------------------------------------------------
// ripple_cnt_capture
//
// Purpose:
//   Capture stage for an asynchronous ripple counter. Each counter bit is run
//   through a 2-flop synchronizer into the clk domain. A capture then samples
//   the synchronized value until it has matched itself on SETTLE_CYCLES
//   consecutive cycles. If that does not happen within MAX_TRIES cycles, the
//   current value is forced out and timeout_err is flagged. The result is
//   held behind a valid/ready handshake.
//
// Optional feature:
//   CAPTURE_DELTA_EN - when defined, keeps the previously accepted count and
//                      reports out_delta = out_count - prev_count (mod 2^WIDTH).
//                      When undefined, out_delta is tied to 0.
//
// Ports:
//   clk          in   single clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   cnt_in       in   ripple counter Q outputs (asynchronous to clk)
//   capture_req  in   one-cycle capture request, honoured only when idle
//   busy         out  capture in progress or result waiting
//   out_valid    out  result available
//   out_ready    in   consumer accepts the result
//   out_count    out  captured count
//   out_delta    out  difference from the previously accepted count
//   timeout_err  out  result was forced without settling
// ---------------------------------------------------------------------------
module ripple_cnt_capture #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_TRIES     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             capture_req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_count,
  output logic [WIDTH-1:0] out_delta,
  output logic             timeout_err
);

  localparam int MW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [MW-1:0] SETTLE_L = MW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] MAX_L    = TW'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_count_q, out_count_d;
  logic             timeout_err_q, timeout_err_d;
`ifdef CAPTURE_DELTA_EN
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic [WIDTH-1:0] out_delta_q, out_delta_d;
`endif

  logic [WIDTH-1:0] sync_val_s;
  logic             same_s;
  logic [MW-1:0]    match_inc_s;
  logic [TW-1:0]    tries_inc_s;
  logic             accept_s;

  assign sync_val_s  = sync2_q;
  assign same_s      = (sync_val_s == sample_q);
  assign match_inc_s = match_cnt_q + {{(MW-1){1'b0}}, 1'b1};
  assign tries_inc_s = tries_q + {{(TW-1){1'b0}}, 1'b1};
  assign accept_s    = out_valid_q & out_ready;

  // Two-flop synchronizer on every ripple counter bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {WIDTH{1'b0}};
      sync2_q <= {WIDTH{1'b0}};
    end else begin
      sync1_q <= cnt_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and next-output logic for the capture FSM
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    match_cnt_d   = match_cnt_q;
    tries_d       = tries_q;
    busy_d        = busy_q;
    out_valid_d   = out_valid_q;
    out_count_d   = out_count_q;
    timeout_err_d = timeout_err_q;
`ifdef CAPTURE_DELTA_EN
    prev_count_d  = prev_count_q;
    out_delta_d   = out_delta_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (capture_req) begin
          state_d     = ST_SAMPLE;
          sample_d    = sync_val_s;
          match_cnt_d = {MW{1'b0}};
          tries_d     = {TW{1'b0}};
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SAMPLE: begin
        tries_d = tries_inc_s;
        // A mismatch restarts the stability run from the new value
        if (same_s) begin
          match_cnt_d = match_inc_s;
        end else begin
          match_cnt_d = {MW{1'b0}};
          sample_d    = sync_val_s;
        end
        // Settling wins over timeout when both happen on the same edge
        if (same_s && (match_inc_s == SETTLE_L)) begin
          state_d       = ST_HOLD;
          out_valid_d   = 1'b1;
          out_count_d   = sample_q;
          timeout_err_d = 1'b0;
`ifdef CAPTURE_DELTA_EN
          out_delta_d   = sample_q - prev_count_q;
`endif
        end else if (tries_inc_s == MAX_L) begin
          state_d       = ST_HOLD;
          out_valid_d   = 1'b1;
          out_count_d   = sync_val_s;
          timeout_err_d = 1'b1;
`ifdef CAPTURE_DELTA_EN
          out_delta_d   = sync_val_s - prev_count_q;
`endif
        end else begin
          state_d = ST_SAMPLE;
        end
      end

      ST_HOLD: begin
        if (accept_s) begin
          state_d      = ST_IDLE;
          out_valid_d  = 1'b0;
          busy_d       = 1'b0;
`ifdef CAPTURE_DELTA_EN
          prev_count_d = out_count_q;
`endif
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sample_q      <= {WIDTH{1'b0}};
      match_cnt_q   <= {MW{1'b0}};
      tries_q       <= {TW{1'b0}};
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_count_q   <= {WIDTH{1'b0}};
      timeout_err_q <= 1'b0;
`ifdef CAPTURE_DELTA_EN
      prev_count_q  <= {WIDTH{1'b0}};
      out_delta_q   <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      match_cnt_q   <= match_cnt_d;
      tries_q       <= tries_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_count_q   <= out_count_d;
      timeout_err_q <= timeout_err_d;
`ifdef CAPTURE_DELTA_EN
      prev_count_q  <= prev_count_d;
      out_delta_q   <= out_delta_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_count   = out_count_q;
  assign timeout_err = timeout_err_q;
`ifdef CAPTURE_DELTA_EN
  assign out_delta   = out_delta_q;
`else
  assign out_delta   = {WIDTH{1'b0}};
`endif

endmodule

// File: doc/ripple_cnt_capture.md
# ripple_cnt_capture

Synchronous capture stage downstream of the asynchronous ripple counter built from T flip-flops. The ripple counter's bits settle at different times, so a plain register would catch mid-ripple garbage. This block synchronizes each counter bit into the `clk` domain and waits until the value is stable for a programmable number of cycles. It then presents the count, and optionally the modulo difference from the previous capture, over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 4 — ripple counter width and output width.
- `SETTLE_CYCLES`, 2 — consecutive matching samples required to accept a value; must be ≥ 1.
- `MAX_TRIES`, 8 — maximum sample cycles per capture before forcing a result; must be > `SETTLE_CYCLES`.

Ports:
- `clk` input 1 — single clock; all state is on its rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `cnt_in` input WIDTH — ripple counter Q outputs; asynchronous to `clk`.
- `capture_req` input 1 — one-cycle request to capture; honoured only in IDLE.
- `busy` output 1 — high in SAMPLE and HOLD.
- `out_valid` output 1 — capture result is available.
- `out_ready` input 1 — consumer accepts the result.
- `out_count` output WIDTH — captured count.
- `out_delta` output WIDTH — `out_count` minus the previously accepted count, modulo 2^WIDTH.
- `timeout_err` output 1 — the result was forced after `MAX_TRIES` attempts without settling.

## Operation
- Synchronizer:
  - 2-flop synchronizer per bit of `cnt_in`.
  - The output `sync_val` trails `cnt_in` by 2 cycles.
- IDLE:
  - `busy=0`, `out_valid=0`.
  - On `capture_req=1`: go to SAMPLE, `sample <= sync_val`, `match_cnt <= 0`, `tries <= 0`.
- SAMPLE, each cycle:
  - `tries` increments.
  - If `sync_val == sample`, `match_cnt` increments; otherwise `match_cnt <= 0` and `sample <= sync_val`.
  - When a match brings `match_cnt` to `SETTLE_CYCLES`: go to HOLD, `out_count <= sample`, `timeout_err <= 0`.
  - Otherwise, when `tries` reaches `MAX_TRIES`: go to HOLD, `out_count <= sync_val`, `timeout_err <= 1`.
  - The settle condition has priority over timeout when both occur in the same cycle.
- HOLD:
  - `out_valid=1`; `out_count`, `out_delta` and `timeout_err` are held stable.
  - On `out_valid && out_ready`: `prev_count <= out_count`, then go to IDLE.
- `out_delta` is `out_count - prev_count` in WIDTH-bit wrap-around arithmetic. It is registered together with `out_count`.
- `capture_req` while `busy=1` is ignored; it is not queued.
- Reset:
  - Clears the synchronizer, `sample`, `match_cnt`, `tries` and `prev_count` to 0, and sets the state to IDLE.
  - All outputs go to 0 immediately, including when reset is asserted mid-SAMPLE or mid-HOLD.
  - The first capture after reset uses `prev_count=0`.

## Timing
- Latency with `cnt_in` stable for at least 2 cycles before the request:
  - `capture_req` is sampled at edge 0.
  - `out_valid` rises after edge `SETTLE_CYCLES` (edge 2 with defaults).
- Worst case: `out_valid` rises after edge `MAX_TRIES`.
- Handshake:
  - Transfer occurs on a rising edge with `out_valid=1` and `out_ready=1`.
  - `out_valid` is low in the following cycle.
  - `out_ready` may be held high permanently.
- At least one IDLE cycle separates captures, so the minimum request-to-request spacing is `SETTLE_CYCLES + 2` cycles.
- Output flag changes occur only in the cycle after an edge; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CAPTURE_DELTA_EN`.
- Defined: `prev_count` and the subtractor are built, and `out_delta` behaves as specified.
- Undefined: no `prev_count` register and no subtractor; `out_delta` is constant 0. All other behaviour is identical.

## Test plan
Defaults throughout: `WIDTH=4`, `SETTLE_CYCLES=2`, `MAX_TRIES=8`.
- Reset: assert `rst` mid-SAMPLE with `cnt_in=9` → `busy`, `out_valid`, `out_count`, `out_delta` and `timeout_err` are 0 immediately. After release, the next capture of 9 gives `out_delta=9`.
- Stable capture: `cnt_in=5` held for 4 cycles, pulse `capture_req`, `out_ready=1` → `out_valid` after edge 2 for 1 cycle, `out_count=5`, `out_delta=5` (with `CAPTURE_DELTA_EN`), `timeout_err=0`.
- Wrap-around: accept 14, then capture 3 → `out_delta=5`.
- Unstable input: `cnt_in` changes every cycle → `out_valid` after edge 8 with `timeout_err=1`. Then hold `cnt_in=7` and capture again → `timeout_err=0`, `out_count=7`.
- Backpressure: `out_ready=0` for 10 cycles in HOLD while `cnt_in` changes and `capture_req` pulses → outputs unchanged and the requests are dropped. Raise `out_ready` → one transfer, then IDLE.
- Macro off: build without `CAPTURE_DELTA_EN`, capture 6 → `out_delta=0`, `out_count=6`.
